// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the ID-stage operands, instruction fields and control bundle on
// every rising edge and presents them to EX one cycle later. A load in EX
// whose destination feeds the instruction in ID stalls PC and IF/ID for one
// cycle and sends a bubble into EX. A branch flush and a downstream hold are
// also handled here.
// Optional build macro: ID_EX_STALL_CNT_EN adds a 32-bit load-use stall counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              stall_id
);

  logic              r_valid;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [CTRL_W-1:0] r_ctrl;

  logic w_load_use;
  logic w_bubble;

  // A load in EX (MemRead, bit 1) writing a non-zero register read by ID.
  // r_valid is cleared by reset, so an active reset also drops the stall.
  assign w_load_use = r_valid & r_ctrl[1] & (r_rt != 5'd0) & id_valid &
                      ((r_rt == id_rs) | (r_rt == id_rt));

  // Flush kills the ID instruction, so freezing IF/ID for it is pointless.
  assign stall_id = hold | (w_load_use & ~flush);

  // Any reason for EX not to receive the current ID instruction.
  assign w_bubble = flush | w_load_use | ~id_valid;

  // Pipeline register: hold freezes, otherwise capture or insert a bubble.
  // Data fields always load so only the qualifying fields are muxed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_ctrl  <= '0;
    end else if (!hold) begin
      r_rd1 <= id_rd1;
      r_rd2 <= id_rd2;
      r_imm <= id_imm;
      r_pc4 <= id_pc4;
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_rs    <= '0;
        r_rt    <= '0;
        r_rd    <= '0;
        r_ctrl  <= '0;
      end else begin
        r_valid <= 1'b1;
        r_rs    <= id_rs;
        r_rt    <= id_rt;
        r_rd    <= id_rd;
        r_ctrl  <= id_ctrl;
      end
    end
  end

  assign ex_valid = r_valid;
  assign ex_rs    = r_rs;
  assign ex_rt    = r_rt;
  assign ex_rd    = r_rd;
  assign ex_rd1   = r_rd1;
  assign ex_rd2   = r_rd2;
  assign ex_imm   = r_imm;
  assign ex_pc4   = r_pc4;
  assign ex_ctrl  = r_ctrl;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count edges on which a load-use stall actually takes effect; wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_load_use & ~flush & ~hold) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX contents are pushed to a
// scoreboard when ID stimulus is driven and popped after the capturing edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [7:0]  ctrl;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [4:0]  id_rd = '0;
  logic [31:0] id_rd1 = '0;
  logic [31:0] id_rd2 = '0;
  logic [31:0] id_imm = '0;
  logic [31:0] id_pc4 = '0;
  logic [7:0]  id_ctrl = '0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;

  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [7:0]  ex_ctrl;
  logic        stall_id;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int unsigned exp_cnt = 0;
`endif

  ex_t ex_o;
  ex_t exp_v;
  ex_t held;
  ex_t sb[$];
  int  total = 0;
  int  bad = 0;

  id_ex_stage #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_ctrl(ex_ctrl),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  assign ex_o = {ex_valid, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_ctrl};

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] base, input logic [7:0] ctrl);
    id_valid = v;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_rd1 = base + 32'h1;
    id_rd2 = base + 32'h2;
    id_imm = base + 32'h3;
    id_pc4 = base + 32'h4;
    id_ctrl = ctrl;
  endtask

  // Expected EX contents if the present ID instruction is captured.
  function automatic ex_t exp_cap();
    return {1'b1, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_pc4, id_ctrl};
  endfunction

  // Expected EX contents for a bubble: only the data fields follow ID.
  function automatic ex_t exp_bub();
    return {1'b0, 5'd0, 5'd0, 5'd0, id_rd1, id_rd2, id_imm, id_pc4, 8'd0};
  endfunction

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    total++;
    if (ex_o !== ex_t'(0)) begin
      bad++; $display("FAIL rst_init got=%h exp=0", ex_o);
    end
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL rst_init_stall got=%b exp=0", stall_id);
    end
`ifdef ID_EX_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt);
    end
`endif
    @(negedge clk) rst = 1'b1;
    // lw r8 into EX, then an add reading r8 in ID -> stall pending
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 8'h0A);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL rst_pre got=%h exp=%h", ex_o, exp_v);
    end
    @(negedge clk) set_id(1'b1, 5'd8, 5'd9, 5'd10, 32'h200, 8'h01);
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL rst_pre_stall got=%b exp=1", stall_id);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ex_o !== ex_t'(0)) begin
      bad++; $display("FAIL rst_async got=%h exp=0", ex_o);
    end
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL rst_async_stall got=%b exp=0", stall_id);
    end
    @(negedge clk) rst = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00);
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd5;
    id_rd1 = 32'h11; id_rd2 = 32'h22; id_imm = 32'h33; id_pc4 = 32'h44; id_ctrl = 8'h01;
    sb.push_back({1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 32'h44, 8'h01});
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL pt_stall got=%b exp=0", stall_id);
    end
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL pt_cap got=%h exp=%h", ex_o, exp_v);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk) set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h300, 8'h0A);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL lu_lw got=%h exp=%h", ex_o, exp_v);
    end
    @(negedge clk) set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'h400, 8'h01);
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL lu_stall got=%b exp=1", stall_id);
    end
    sb.push_back(exp_bub());
    @(posedge clk); #1;
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt++;
`endif
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL lu_bubble got=%h exp=%h", ex_o, exp_v);
    end
    // Same add is re-presented because IF/ID was frozen
    @(negedge clk); #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL lu_stall_once got=%b exp=0", stall_id);
    end
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL lu_add got=%h exp=%h", ex_o, exp_v);
    end
`ifdef ID_EX_STALL_CNT_EN
    total++;
    if (stall_cnt !== exp_cnt) begin
      bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk) set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h500, 8'h0A);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL b2b_lw1 got=%h exp=%h", ex_o, exp_v);
    end
    // second load uses r8 as base address
    @(negedge clk) set_id(1'b1, 5'd8, 5'd9, 5'd0, 32'h600, 8'h0A);
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL b2b_stall got=%b exp=1", stall_id);
    end
    sb.push_back(exp_bub());
    @(posedge clk); #1;
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt++;
`endif
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL b2b_bubble got=%h exp=%h", ex_o, exp_v);
    end
    @(negedge clk);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL b2b_lw2 got=%h exp=%h", ex_o, exp_v);
    end
    // independent instruction after lw r9: no stall
    @(negedge clk) set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h680, 8'h01);
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL b2b_indep_stall got=%b exp=0", stall_id);
    end
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL b2b_indep got=%h exp=%h", ex_o, exp_v);
    end
  endtask

  task automatic test_no_false_hazard();
    // lw writing $0, then a reader of $0
    @(negedge clk) set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h700, 8'h0A);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL nf_lw0 got=%h exp=%h", ex_o, exp_v);
    end
    @(negedge clk) set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h710, 8'h01);
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL nf_r0_stall got=%b exp=0", stall_id);
    end
    // next ID is lw r8; after it the ID slot is empty but names r8
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h720, 8'h0A);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL nf_lw8 got=%h exp=%h", ex_o, exp_v);
    end
    @(negedge clk) set_id(1'b0, 5'd8, 5'd8, 5'd5, 32'h730, 8'h01);
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL nf_invalid_stall got=%b exp=0", stall_id);
    end
    sb.push_back(exp_bub());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL nf_invalid got=%h exp=%h", ex_o, exp_v);
    end
  endtask

  task automatic test_flush();
    @(negedge clk) set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h800, 8'h0A);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL fl_lw got=%h exp=%h", ex_o, exp_v);
    end
    @(negedge clk) set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'h810, 8'h01);
    flush = 1'b1;
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL fl_stall got=%b exp=0", stall_id);
    end
    sb.push_back(exp_bub());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL fl_bubble got=%h exp=%h", ex_o, exp_v);
    end
`ifdef ID_EX_STALL_CNT_EN
    total++;
    if (stall_cnt !== exp_cnt) begin
      bad++; $display("FAIL fl_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
    end
`endif
    @(negedge clk) flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00);
  endtask

  task automatic test_hold();
    @(negedge clk) set_id(1'b1, 5'd1, 5'd8, 5'd7, 32'h900, 8'h0A);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    held = exp_v;
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL hd_pre got=%h exp=%h", ex_o, exp_v);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hold = 1'b1;
      flush = (k == 1);
      set_id(1'b1, 5'd8, 5'(k + 10), 5'(k + 20), 32'hA00 + 32'(k * 16), 8'h01);
      #1;
      total++;
      if (stall_id !== 1'b1) begin
        bad++; $display("FAIL hd_stall[%0d] got=%b exp=1", k, stall_id);
      end
      sb.push_back(held);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if (ex_o !== exp_v) begin
        bad++; $display("FAIL hd_frozen[%0d] got=%h exp=%h", k, ex_o, exp_v);
      end
`ifdef ID_EX_STALL_CNT_EN
      total++;
      if (stall_cnt !== exp_cnt) begin
        bad++; $display("FAIL hd_cnt[%0d] got=%0d exp=%0d", k, stall_cnt, exp_cnt);
      end
`endif
    end
    // hold drops: lw r8 still in EX, add reading r8 stalls once
    @(negedge clk);
    hold = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'hB00, 8'h01);
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL hd_post_stall got=%b exp=1", stall_id);
    end
    sb.push_back(exp_bub());
    @(posedge clk); #1;
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt++;
`endif
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL hd_post_bubble got=%h exp=%h", ex_o, exp_v);
    end
    @(negedge clk);
    sb.push_back(exp_cap());
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if (ex_o !== exp_v) begin
      bad++; $display("FAIL hd_resume got=%h exp=%h", ex_o, exp_v);
    end
`ifdef ID_EX_STALL_CNT_EN
    total++;
    if (stall_cnt !== exp_cnt) begin
      bad++; $display("FAIL hd_post_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_back_to_back();
    test_no_false_hazard();
    test_flush();
    test_hold();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
